fpcvt_pipe: RTL

//  Parametrised, pipelined successor to the combinational linear-to-float converter.
//  - Converts a two's-complement IN_W-bit sample into sign / EXP_W exponent / SIG_W significand.
//  - Encoded value = (-1)^S * F * 2^E, with per-sample round-to-nearest or truncate.
//  - Saturates on overflow, with a valid/ready stream on both sides and a saturation-event counter.
//  - Sits between the sample source and the packer or serialiser.

---
 rtl/fpcvt_pkg.sv | 18 +
 rtl/fpcvt_lzc.sv | 22 ++
 rtl/fpcvt_pipe.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fpcvt_pkg.sv
// Shared widths and derived constants for the pipelined linear-to-float converter.
package fpcvt_pkg;

  localparam int DEF_IN_W  = 12;
  localparam int DEF_EXP_W = 3;
  localparam int DEF_SIG_W = 4;
  localparam int DEF_CNT_W = 16;

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Exponent of a magnitude whose MSB sits just below the sign bit, plus one.
  function automatic int exp_bias(input int in_w, input int sig_w);
    return in_w - sig_w;
  endfunction

endpackage

// File: rtl/fpcvt_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fpcvt_lzc
  import fpcvt_pkg::*;
#(
  parameter int W  = DEF_IN_W,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  // Ascending scan: the highest set bit is the last to overwrite the count.
  always_comb begin
    count_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) begin
        count_o = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage valid/ready linear-to-float converter with rounding, saturation
// and a sticky saturation-event counter.
module fpcvt_pipe
  import fpcvt_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int EXP_W = DEF_EXP_W,
  parameter int SIG_W = DEF_SIG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
);

  localparam int LZ_W = $clog2(IN_W + 1);
  localparam int BIAS = exp_bias(IN_W, SIG_W);
  localparam int EMAX = exp_max(EXP_W);
  localparam logic [LZ_W-1:0]  BIAS_L   = LZ_W'(BIAS);
  localparam logic [EXP_W:0]   EMAX_EXT = (EXP_W + 1)'(EMAX);

  logic load1, load2, load3;

  logic             v1_q, s1_sign_q, s1_sat_q, s1_round_q;
  logic [IN_W-1:0]  s1_mag_q;
  logic             neg_max;
  logic [IN_W-1:0]  mag_d;

  logic             v2_q, s2_sign_q, s2_sat_q, s2_round_q, s2_rbit_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SIG_W-1:0] s2_sig_q;
  logic [LZ_W-1:0]  lz, e_full;
  logic [EXP_W-1:0] exp2_d;
  logic [SIG_W-1:0] sig2_d;
  logic             rbit2_d;

  logic             out_valid_q, out_sign_q, out_sat_q;
  logic [EXP_W-1:0] out_exp_q, exp3_d;
  logic [SIG_W-1:0] out_sig_q, sig3_d;
  logic             sat3_d;
  logic [SIG_W:0]   sum3;
  logic [EXP_W:0]   e_ext;

  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  // A stage loads when empty or when its contents move on this edge.
  assign load3    = !out_valid_q || out_ready;
  assign load2    = !v2_q || load3;
  assign load1    = !v1_q || load2;
  assign in_ready = load1;

  always_comb begin
    neg_max = (in_data == {1'b1, {(IN_W-1){1'b0}}});
    mag_d   = in_data[IN_W-1] ? -in_data : in_data;
    if (neg_max) begin
      mag_d = {1'b0, {(IN_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sat_q   <= 1'b0;
      s1_round_q <= 1'b0;
      s1_mag_q   <= '0;
    end else if (load1) begin
      v1_q       <= in_valid;
      s1_sign_q  <= in_data[IN_W-1];
      s1_sat_q   <= neg_max;
      s1_round_q <= in_round;
      s1_mag_q   <= mag_d;
    end
  end

  fpcvt_lzc #(
    .W  (IN_W),
    .CW (LZ_W)
  ) u_lzc (
    .data_i  (s1_mag_q),
    .count_o (lz)
  );

  // Shift just far enough that the magnitude fits SIG_W bits; r is the first dropped bit.
  always_comb begin
    e_full  = (lz < BIAS_L) ? (BIAS_L - lz) : '0;
    exp2_d  = EXP_W'(e_full);
    sig2_d  = SIG_W'(s1_mag_q >> e_full);
    rbit2_d = (e_full != '0) ? 1'(s1_mag_q >> (e_full - LZ_W'(1))) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q       <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_sat_q   <= 1'b0;
      s2_round_q <= 1'b0;
      s2_rbit_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_sig_q   <= '0;
    end else if (load2) begin
      v2_q       <= v1_q;
      s2_sign_q  <= s1_sign_q;
      s2_sat_q   <= s1_sat_q;
      s2_round_q <= s1_round_q;
      s2_rbit_q  <= rbit2_d;
      s2_exp_q   <= exp2_d;
      s2_sig_q   <= sig2_d;
    end
  end

  // A carry out of the significand renormalises; exponent overflow clamps to max.
  always_comb begin
    sum3   = {1'b0, s2_sig_q} + {{SIG_W{1'b0}}, s2_round_q & s2_rbit_q};
    sig3_d = sum3[SIG_W-1:0];
    e_ext  = {1'b0, s2_exp_q};
    sat3_d = s2_sat_q;
    if (sum3[SIG_W]) begin
      sig3_d = {1'b1, {(SIG_W-1){1'b0}}};
      e_ext  = {1'b0, s2_exp_q} + {{EXP_W{1'b0}}, 1'b1};
    end
    exp3_d = e_ext[EXP_W-1:0];
    if (e_ext > EMAX_EXT) begin
      exp3_d = EXP_W'(EMAX);
      sig3_d = '1;
      sat3_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (load3) begin
      out_valid_q <= v2_q;
      out_sign_q  <= s2_sign_q;
      out_exp_q   <= exp3_d;
      out_sig_q   <= sig3_d;
      out_sat_q   <= sat3_d;
    end
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_valid_q && out_ready && out_sat_q && !(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_sig   = out_sig_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_cnt_q;

endmodule
